// File: rtl/vga_timing_gen.sv
// Programmable VGA/DVI timing generator with selectable test pattern.
// Outputs are registered from the pre-edge (h,v) counters, one cycle behind them.
module vga_timing_gen #(
    parameter int   H_VIS      = 800,
    parameter int   H_FP       = 40,
    parameter int   H_SYNC     = 128,
    parameter int   H_BP       = 88,
    parameter int   V_VIS      = 600,
    parameter int   V_FP       = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BP       = 23,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   COLOR_BITS = 3,
    parameter int   BORDER     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  blank,
    output logic [10:0]           x,
    output logic [9:0]            y,
    output logic                  frame_start,
    output logic [7:0]            frame_count
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int CW    = 3 * COLOR_BITS;

    localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
    localparam logic [10:0] H_VIS_L = 11'(H_VIS);
    localparam logic [9:0]  V_VIS_L = 10'(V_VIS);
    localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] H_BL    = 11'(BORDER);
    localparam logic [10:0] H_BR    = 11'(H_VIS - BORDER);
    localparam logic [9:0]  V_BT    = 10'(BORDER);
    localparam logic [9:0]  V_BB    = 10'(V_VIS - BORDER);
    localparam logic [10:0] BAR_W   = 11'(H_VIS / 8);

    localparam logic [COLOR_BITS-1:0] MAX  = '1;
    localparam logic [COLOR_BITS-1:0] ZERO = '0;

    logic [10:0]   h_p0;
    logic [9:0]    v_p0;
    logic [1:0]    mode_q;
    logic          started;
    logic          at_origin;
    logic          h_wrap;
    logic [1:0]    mode_eff;
    logic          hs_act;
    logic          vs_act;
    logic          blank_d;
    logic [CW-1:0] rgb_d;

    // Colour for a visible pixel; blanking is applied by the caller.
    function automatic logic [CW-1:0] pattern(input logic [1:0] m,
                                              input logic [10:0] hh,
                                              input logic [9:0] vv);
        logic [10:0]   bar;
        logic [2:0]    idx;
        logic [CW-1:0] c;
        c   = '0;
        bar = hh / BAR_W;
        idx = (bar > 11'd7) ? 3'd7 : bar[2:0];
        case (m)
            2'd1: if (hh < H_BL || hh >= H_BR || vv < V_BT || vv >= V_BB)
                      c = {ZERO, ZERO, MAX};
            2'd2: c = {(idx[2] ? MAX : ZERO), (idx[1] ? MAX : ZERO),
                       (idx[0] ? MAX : ZERO)};
            2'd3: if (hh[5] ^ vv[5]) c = {MAX, MAX, MAX};
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        at_origin = (h_p0 == 11'd0) && (v_p0 == 10'd0);
        h_wrap    = (h_p0 == H_LAST);
        // The frame's pattern takes effect at its very first pixel.
        mode_eff  = at_origin ? mode : mode_q;
        hs_act    = (h_p0 >= HS_BEG) && (h_p0 < HS_END);
        vs_act    = (v_p0 >= VS_BEG) && (v_p0 < VS_END);
        blank_d   = (h_p0 >= H_VIS_L) || (v_p0 >= V_VIS_L);
        rgb_d     = blank_d ? '0 : pattern(mode_eff, h_p0, v_p0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_p0        <= '0;
            v_p0        <= '0;
            mode_q      <= 2'd0;
            started     <= 1'b0;
            frame_count <= 8'd0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            blank       <= 1'b1;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            if (h_wrap) begin
                h_p0 <= '0;
                v_p0 <= (v_p0 == V_LAST) ? 10'd0 : v_p0 + 10'd1;
            end else begin
                h_p0 <= h_p0 + 11'd1;
            end
            // The first frame after reset is not counted as completed.
            if (at_origin) begin
                mode_q  <= mode;
                started <= 1'b1;
                if (started) frame_count <= frame_count + 8'd1;
            end
            {red, green, blue} <= rgb_d;
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            blank       <= blank_d;
            x           <= h_p0;
            y           <= v_p0;
            frame_start <= at_origin;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced 64x48 raster so whole frames fit the run.
module tb_vga_timing_gen;

    localparam int   HV = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int   VV = 48, VFP = 1, VS = 2, VBP = 3;
    localparam int   HT = HV + HFP + HS + HBP;
    localparam int   VT = VV + VFP + VS + VBP;
    localparam int   FRAME = HT * VT;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;
    localparam int   BRD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [2:0]  red, green, blue;
    logic        hsync, vsync, blank, frame_start;
    logic [10:0] x;
    logic [9:0]  y;
    logic [7:0]  frame_count;

    int total = 0;
    int bad   = 0;
    int n     = -1;  // index of the pixel currently on the outputs, -1 while in reset
    int cur_mode = 0;

    vga_timing_gen #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .COLOR_BITS(3), .BORDER(BRD)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .x(x), .y(y), .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] model(input int pix, input int m);
        int h, v, k, i;
        logic [2:0] r, g, b;
        logic hs_o, vs_o, bl, fs;
        h = pix % HT;
        v = (pix / HT) % VT;
        k = pix / FRAME;
        bl = !(h < HV && v < VV);
        r = 3'd0; g = 3'd0; b = 3'd0;
        if (!bl) begin
            case (m)
                1: if (h < BRD || h >= HV - BRD || v < BRD || v >= VV - BRD) b = 3'd7;
                2: begin
                    i = h / (HV / 8);
                    if (i > 7) i = 7;
                    r = ((i / 4) % 2 == 1) ? 3'd7 : 3'd0;
                    g = ((i / 2) % 2 == 1) ? 3'd7 : 3'd0;
                    b = (i % 2 == 1) ? 3'd7 : 3'd0;
                end
                3: if (((h / 32) + (v / 32)) % 2 == 1) begin r = 3'd7; g = 3'd7; b = 3'd7; end
                default: ;
            endcase
        end
        hs_o = (h >= HV + HFP && h < HV + HFP + HS) ? HSP : !HSP;
        vs_o = (v >= VV + VFP && v < VV + VFP + VS) ? VSP : !VSP;
        fs = (h == 0 && v == 0);
        return {r, g, b, hs_o, vs_o, bl, 11'(h), 10'(v), fs, 8'(k % 256)};
    endfunction

    function automatic logic [41:0] reset_vec();
        return {9'd0, !HSP, !VSP, 1'b1, 11'd0, 10'd0, 1'b0, 8'd0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) begin
            n++;
            if (n % FRAME == 0) cur_mode = int'(mode);
        end
        @(negedge clk);
        chk("pix", 64'({red, green, blue, hsync, vsync, blank, x, y, frame_start, frame_count}),
            64'((n < 0) ? reset_vec() : model(n, cur_mode)));
    endtask

    task automatic run_to(input int tx, input int ty);
        bit found = 0;
        for (int i = 0; i <= FRAME && !found; i++) begin
            step();
            if (n >= 0 && n % HT == tx && (n / HT) % VT == ty) found = 1;
        end
        chk("run_to_found", 64'(found), 64'd1);
    endtask

    task automatic chk_rgb(input string tag, input logic [8:0] exp);
        chk(tag, 64'({red, green, blue}), 64'(exp));
    endtask

    initial begin
        reset = 1'b1;
        mode  = 2'd0;
        #2;
        // Reset state
        chk("rst_hsync", 64'(hsync), 64'd1);
        chk("rst_vsync", 64'(vsync), 64'd0);
        chk("rst_blank", 64'(blank), 64'd1);
        step();
        step();
        reset = 1'b0;
        step();
        chk("first_fs", 64'(frame_start), 64'd1);
        chk("first_fc", 64'(frame_count), 64'd0);
        // Line timing in mode 0
        run_to(HV - 1, 0); chk("blank_x63", 64'(blank), 64'd0);
        step();            chk("blank_x64", 64'(blank), 64'd1);
        run_to(67, 0);     chk("hs_x67", 64'(hsync), 64'd1);
        step();            chk("hs_x68", 64'(hsync), 64'd0);
        run_to(75, 0);     chk("hs_x75", 64'(hsync), 64'd0);
        step();            chk("hs_x76", 64'(hsync), 64'd1);
        run_to(0, VV + VFP); chk("vs_y49", 64'(vsync), 64'd1);
        run_to(0, VV + VFP + VS); chk("vs_y51", 64'(vsync), 64'd0);
        run_to(0, 0);
        chk("fs2", 64'(frame_start), 64'd1);
        chk("fc_after_fs2", 64'(frame_count), 64'd1);
        chk("fs2_period", 64'(n), 64'(FRAME));
        // Border pattern, then a mid-frame switch to checkerboard
        mode = 2'd1;
        run_to(0, 0);       chk_rgb("b_0_0", 9'o007);
        run_to(3, 24);      chk_rgb("b_3_24", 9'o007);
        step();             chk_rgb("b_4_24", 9'o000);
        run_to(32, 24);     chk_rgb("b_32_24", 9'o000);
        run_to(70, 24);     chk_rgb("b_70_24", 9'o000);
        mode = 2'd3;
        run_to(HV - 1, 30); chk_rgb("b_63_30", 9'o007);
        run_to(HV - 1, VV - 1); chk_rgb("b_63_47", 9'o007);
        run_to(32, 0);      chk_rgb("c_32_0", 9'o777);
        run_to(32, 32);     chk_rgb("c_32_32", 9'o000);
        // Colour bars
        mode = 2'd2;
        run_to(0, 5);       chk_rgb("bar_x0", 9'o000);
        run_to(8, 5);       chk_rgb("bar_x8", 9'o007);
        run_to(36, 5);      chk_rgb("bar_x36", 9'o700);
        run_to(63, 5);      chk_rgb("bar_x63", 9'o777);
        run_to(36, 40);     chk_rgb("bar_x36_y40", 9'o700);
        // Random mode changes, checked every pixel against the model
        for (int i = 0; i < 3 * FRAME; i++) begin
            if ($urandom_range(0, 499) == 0) mode = 2'($urandom_range(0, 3));
            step();
        end
        // Asynchronous reset mid-frame
        run_to(40, 20);
        #2 reset = 1'b1;
        n = -1;
        #1;
        chk("arst_vec", 64'({red, green, blue, hsync, vsync, blank, x, y, frame_start, frame_count}),
            64'(reset_vec()));
        chk("arst_hsync", 64'(hsync), 64'd1);
        step();
        reset = 1'b0;
        mode  = 2'd3;
        step();
        chk("arst_x", 64'(x), 64'd0);
        chk("arst_y", 64'(y), 64'd0);
        chk("arst_fs", 64'(frame_start), 64'd1);
        chk("arst_fc", 64'(frame_count), 64'd0);
        run_to(32, 0);      chk_rgb("arst_c_32_0", 9'o777);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
